// File: rtl/uart_tx.sv
// uart_tx: asynchronous serial transmitter.
// Accepts a parallel word over a valid/ready handshake and shifts it out
// LSB-first as start / data / optional parity / stop bits on a single line.
// All outputs come straight from flops; bit timing comes from a cycle counter.
module uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 valid,
    output logic                 ready,
    output logic                 tx,
    output logic                 busy
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int CNT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PAR,
        ST_STOP
    } state_t;

    state_t               state;
    state_t               state_n;
    logic [DATA_BITS-1:0] shift_reg;
    logic [DATA_BITS-1:0] shift_n;
    logic [CNT_W-1:0]     bitcnt;
    logic [CNT_W-1:0]     bitcnt_n;
    logic [BAUD_W-1:0]    baud;
    logic [BAUD_W-1:0]    baud_n;
    logic                 par_bit;
    logic                 par_n;
    logic                 baud_last;
    logic                 tx_n;
    logic                 ready_n;
    logic                 busy_n;

    // State, datapath and output registers; reset idles the line high at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            shift_reg <= '0;
            bitcnt    <= '0;
            baud      <= '0;
            par_bit   <= 1'b0;
            tx        <= 1'b1;
            ready     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            shift_reg <= shift_n;
            bitcnt    <= bitcnt_n;
            baud      <= baud_n;
            par_bit   <= par_n;
            tx        <= tx_n;
            ready     <= ready_n;
            busy      <= busy_n;
        end
    end

    // Next-state and datapath updates; outputs are decoded from the next
    // state so that tx/ready/busy land in flops with no input-to-output path.
    always_comb begin
        state_n   = state;
        shift_n   = shift_reg;
        bitcnt_n  = bitcnt;
        baud_n    = baud;
        par_n     = par_bit;
        baud_last = (baud == BAUD_LAST);
        tx_n      = 1'b1;
        ready_n   = 1'b0;
        busy_n    = 1'b1;

        case (state)
            ST_IDLE: begin
                baud_n = '0;
                if (valid && ready) begin
                    shift_n  = data_in;
                    par_n    = (PARITY == 2) ? ~(^data_in) : (^data_in);
                    bitcnt_n = '0;
                    state_n  = ST_START;
                end
            end
            ST_START: begin
                if (baud_last) begin
                    baud_n  = '0;
                    state_n = ST_DATA;
                end else begin
                    baud_n = baud + BAUD_ONE;
                end
            end
            ST_DATA: begin
                if (baud_last) begin
                    baud_n   = '0;
                    shift_n  = {1'b0, shift_reg[DATA_BITS-1:1]};
                    bitcnt_n = bitcnt + CNT_ONE;
                    if (bitcnt == BIT_LAST) begin
                        if (PARITY != 0) begin
                            state_n = ST_PAR;
                        end else begin
                            state_n = ST_STOP;
                        end
                    end
                end else begin
                    baud_n = baud + BAUD_ONE;
                end
            end
            ST_PAR: begin
                if (baud_last) begin
                    baud_n  = '0;
                    state_n = ST_STOP;
                end else begin
                    baud_n = baud + BAUD_ONE;
                end
            end
            ST_STOP: begin
                if (baud_last) begin
                    baud_n  = '0;
                    state_n = ST_IDLE;
                end else begin
                    baud_n = baud + BAUD_ONE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        case (state_n)
            ST_IDLE: begin
                busy_n  = 1'b0;
                ready_n = 1'b1;
            end
            ST_START: tx_n = 1'b0;
            ST_DATA:  tx_n = shift_n[0];
            ST_PAR:   tx_n = par_n;
            default:  tx_n = 1'b1;
        endcase
    end

endmodule
